// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    CauseNone = 2'b00,
    CauseData = 2'b01,
    CauseMdu  = 2'b10,
    CauseCp0  = 2'b11
  } stall_cause_e;

  typedef enum logic [1:0] {
    MdNone = 2'b00,
    MdMult = 2'b01,
    MdDiv  = 2'b10,
    MdRsvd = 2'b11
  } md_start_e;

  // Tnew lives in a separate array in the top because its width is a parameter.
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       cp0_wr;
    logic [4:0] cp0_idx;
  } sb_entry_t;

  localparam int unsigned DefMultCyc = 5;
  localparam int unsigned DefDivCyc  = 10;
  localparam int unsigned DefEpcIdx  = 14;

endpackage

// File: rtl/mdu_busy_cnt.sv
// MDU busy counter: loads the multiply/divide latency on issue, then counts down to zero.
module mdu_busy_cnt
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYC = DefMultCyc,
  parameter int unsigned DIV_CYC  = DefDivCyc
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [1:0] md_start,
  output logic       mdu_busy
);

  localparam int unsigned CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reserved start encoding falls through to the decrement path.
  always_comb begin
    cnt_d = cnt_q;
    if (load && (md_start == MdMult)) begin
      cnt_d = CW'(MULT_CYC);
    end else if (load && (md_start == MdDiv)) begin
      cnt_d = CW'(DIV_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mdu_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall unit with its own scoreboard of in-flight producers.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned NSRC     = 2,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_CYC = DefMultCyc,
  parameter int unsigned DIV_CYC  = DefDivCyc,
  parameter int unsigned EPC_IDX  = DefEpcIdx
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [NSRC*5-1:0] id_src,
  input  logic [NSRC-1:0]   id_src_used,
  input  logic [NSRC*TW-1:0] id_tuse,
  input  logic [4:0]        id_dst,
  input  logic [TW-1:0]     id_tnew,
  input  logic [1:0]        id_md_start,
  input  logic              id_md_use,
  input  logic              id_cp0_wr,
  input  logic [4:0]        id_cp0_idx,
  input  logic              id_eret,
  input  logic              hold,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        stall_cause,
  output logic              mdu_busy,
  output logic              issue
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cyc,
  output logic [31:0]       stat_issue_cnt
`endif
);

  sb_entry_t     sb_q   [DEPTH];
  sb_entry_t     sb_d   [DEPTH];
  logic [TW-1:0] tnew_q [DEPTH];
  logic [TW-1:0] tnew_d [DEPTH];

  logic data_hz, mdu_hz, cp0_hz, epc_pend;
  stall_cause_e cause;

  always_comb begin
    data_hz  = 1'b0;
    epc_pend = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_q[k].valid && sb_q[k].cp0_wr && (sb_q[k].cp0_idx == 5'(EPC_IDX))) begin
        epc_pend = 1'b1;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (sb_q[k].valid && id_src_used[i] && (sb_q[k].dst != 5'd0) &&
            (sb_q[k].dst == id_src[5*i +: 5]) && (id_tuse[TW*i +: TW] < tnew_q[k])) begin
          data_hz = 1'b1;
        end
      end
    end
  end

  assign mdu_hz = id_md_use & mdu_busy;
  assign cp0_hz = id_eret & epc_pend;

  always_comb begin
    cause = CauseNone;
    if (id_valid) begin
      if (data_hz) begin
        cause = CauseData;
      end else if (mdu_hz) begin
        cause = CauseMdu;
      end else if (cp0_hz) begin
        cause = CauseCp0;
      end
    end
  end

  assign stall       = (cause != CauseNone);
  assign stall_cause = cause;
  assign issue       = id_valid & ~stall & ~hold;

  always_comb begin
    sb_d   = sb_q;
    tnew_d = tnew_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_d[k]   = '0;
        tnew_d[k] = '0;
      end
    end else if (!hold) begin
      sb_d[0]   = '0;
      tnew_d[0] = '0;
      if (issue) begin
        sb_d[0].valid   = 1'b1;
        sb_d[0].dst     = id_dst;
        sb_d[0].cp0_wr  = id_cp0_wr;
        sb_d[0].cp0_idx = id_cp0_idx;
        tnew_d[0]       = id_tnew;
      end
      // Tnew counts down with each stage advanced, saturating at zero.
      for (int k = 1; k < DEPTH; k++) begin
        sb_d[k]   = sb_q[k-1];
        tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q   <= '{default: '0};
      tnew_q <= '{default: '0};
    end else begin
      sb_q   <= sb_d;
      tnew_q <= tnew_d;
    end
  end

  // A flushed issue is dropped from the scoreboard but still starts the MDU.
  mdu_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdu_busy_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (issue),
    .md_start (id_md_start),
    .mdu_busy (mdu_busy)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cyc_q, issue_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cyc_q <= '0;
      issue_cnt_q <= '0;
    end else if (!hold) begin
      if (stall) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (issue) issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign stat_stall_cyc = stall_cyc_q;
  assign stat_issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [3:0]  id_tuse;
  logic [4:0]  id_dst;
  logic [1:0]  id_tnew;
  logic [1:0]  id_md_start;
  logic        id_md_use;
  logic        id_cp0_wr;
  logic [4:0]  id_cp0_idx;
  logic        id_eret;
  logic        hold;
  logic        flush;
  logic        stall;
  logic [1:0]  stall_cause;
  logic        mdu_busy;
  logic        issue;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cyc;
  logic [31:0] stat_issue_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_tuse     (id_tuse),
    .id_dst      (id_dst),
    .id_tnew     (id_tnew),
    .id_md_start (id_md_start),
    .id_md_use   (id_md_use),
    .id_cp0_wr   (id_cp0_wr),
    .id_cp0_idx  (id_cp0_idx),
    .id_eret     (id_eret),
    .hold        (hold),
    .flush       (flush),
    .stall       (stall),
    .stall_cause (stall_cause),
    .mdu_busy    (mdu_busy),
    .issue       (issue)
`ifdef HAZARD_STATS_EN
    ,
    .stat_stall_cyc (stat_stall_cyc),
    .stat_issue_cnt (stat_issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [1:0] tu0, input logic [1:0] tu1,
                        input logic [4:0] dst, input logic [1:0] tnew, input logic [1:0] mds,
                        input logic mdu, input logic cw, input logic [4:0] cidx,
                        input logic er);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_tuse     = {tu1, tu0};
    id_dst      = dst;
    id_tnew     = tnew;
    id_md_start = mds;
    id_md_use   = mdu;
    id_cp0_wr   = cw;
    id_cp0_idx  = cidx;
    id_eret     = er;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic lw_t0();
    set_id(1'b1, 5'd29, 5'd0, 2'b01, 2'd1, 2'd0, 5'd8, 2'd2, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic addu_t0();
    set_id(1'b1, 5'd8, 5'd9, 2'b11, 2'd1, 2'd1, 5'd10, 2'd1, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic mflo();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 5'd9, 2'd1, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic md_op(input logic [1:0] mds);
    set_id(1'b1, 5'd4, 5'd5, 2'b11, 2'd1, 2'd1, 5'd0, 2'd0, mds, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic mtc0(input logic [4:0] idx);
    set_id(1'b1, 5'd8, 5'd0, 2'b01, 2'd2, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0, 1'b1, idx, 1'b0);
  endtask

  task automatic eret();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    idle();
    id_valid = 1'b1;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_cause", 32'(stall_cause), 32'd0);
    chk("rst_busy", 32'(mdu_busy), 32'd0);
    chk("rst_issue", 32'(issue), 32'd1);
    hold = 1'b1;
    settle();
    chk("rst_issue_hold", 32'(issue), 32'd0);
    hold = 1'b0;
    idle();
    tick();
    reset_n = 1'b1;
    tick();

    // Load-use: one data stall, then issue.
    lw_t0();
    settle();
    chk("lw_issue", 32'(issue), 32'd1);
    tick();
    addu_t0();
    settle();
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_cause", 32'(stall_cause), 32'd1);
    chk("lu_noissue", 32'(issue), 32'd0);
    tick();
    chk("lu_stall_clr", 32'(stall), 32'd0);
    chk("lu_issue", 32'(issue), 32'd1);
    idle();
    tick();
    tick();

    // Unused source and dst 0 never stall.
    lw_t0();
    tick();
    set_id(1'b1, 5'd8, 5'd0, 2'b00, 2'd0, 2'd0, 5'd10, 2'd1, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
    settle();
    chk("unused_src", 32'(stall), 32'd0);
    tick();
    set_id(1'b1, 5'd29, 5'd0, 2'b01, 2'd0, 2'd0, 5'd0, 2'd2, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b01, 2'd0, 2'd0, 5'd10, 2'd1, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
    settle();
    chk("dst_zero", 32'(stall), 32'd0);
    idle();
    tick();
    tick();

    // mult then mflo: 5 MDU stall cycles.
    md_op(2'b01);
    tick();
    mflo();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("mult_stall", 32'(stall), 32'd1);
      chk("mult_cause", 32'(stall_cause), 32'd2);
      chk("mult_busy", 32'(mdu_busy), 32'd1);
      tick();
    end
    chk("mult_busy_end", 32'(mdu_busy), 32'd0);
    chk("mflo_issue", 32'(issue), 32'd1);
    tick();

    // div then mflo: 10 stall cycles.
    md_op(2'b10);
    tick();
    mflo();
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("div_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("div_issue", 32'(issue), 32'd1);
    tick();
    idle();

    // Priority: data beats mdu while both pending.
    md_op(2'b01);
    tick();
    lw_t0();
    tick();
    set_id(1'b1, 5'd8, 5'd0, 2'b01, 2'd0, 2'd0, 5'd9, 2'd1, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0);
    settle();
    chk("prio_data0", 32'(stall_cause), 32'd1);
    tick();
    chk("prio_data1", 32'(stall_cause), 32'd1);
    tick();
    chk("prio_mdu0", 32'(stall_cause), 32'd2);
    tick();
    chk("prio_mdu1", 32'(stall_cause), 32'd2);
    tick();
    chk("prio_issue", 32'(issue), 32'd1);
    tick();
    idle();

    // mtc0 EPC then eret: DEPTH cp0 stall cycles.
    mtc0(5'd14);
    tick();
    eret();
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("cp0_stall", 32'(stall), 32'd1);
      chk("cp0_cause", 32'(stall_cause), 32'd3);
      tick();
    end
    chk("eret_issue", 32'(issue), 32'd1);
    tick();
    mtc0(5'd12);
    tick();
    eret();
    settle();
    chk("cp0_other_idx", 32'(stall), 32'd0);
    tick();
    idle();
    tick();
    tick();

    // Hold freezes the scoreboard, so the load-use stall persists.
    lw_t0();
    tick();
    addu_t0();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_noissue", 32'(issue), 32'd0);
      tick();
    end
    hold = 1'b0;
    settle();
    chk("post_hold_stall", 32'(stall), 32'd1);
    tick();
    chk("post_hold_issue", 32'(issue), 32'd1);
    tick();
    idle();
    tick();
    tick();

    // Flush clears the in-flight load.
    lw_t0();
    tick();
    addu_t0();
    flush = 1'b1;
    settle();
    chk("flush_stall_pre", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_issue", 32'(issue), 32'd1);
    tick();
    idle();
    tick();
    tick();

    // Same-cycle flush drops the issuing load.
    lw_t0();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    addu_t0();
    settle();
    chk("flush_drop", 32'(stall), 32'd0);
    tick();
    idle();
    tick();
    tick();

    // Division survives a flush; reset mid-division clears it asynchronously.
    md_op(2'b10);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_div_busy", 32'(mdu_busy), 32'd1);
    tick();
    mflo();
    settle();
    chk("div_mflo_stall", 32'(stall), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_busy", 32'(mdu_busy), 32'd0);
    chk("async_stall", 32'(stall), 32'd0);
`ifdef HAZARD_STATS_EN
    chk("stat_stall_rst", stat_stall_cyc, 32'd0);
    chk("stat_issue_rst", stat_issue_cnt, 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-stage IR-decode stall unit in the pipelined MIPS core.
- Keeps its own shift-register scoreboard of in-flight producers (dst reg, Tnew, CP0 write) for DEPTH stages after ID, so later stages no longer need decoding.
- Generalises the Tuse/Tnew check to NSRC sources. Adds a multi-cycle MDU busy counter and a pipeline hold/flush. Sits beside the ID stage and drives the ID/EX stall.

Parameters:
DEPTH, 2, tracked stages after ID (stage 0 = EX, stage 1 = MEM, ...)
NSRC, 2, source operands checked per ID instruction
TW, 2, width of Tuse/Tnew fields
MULT_CYC, 5, MDU busy cycles loaded on mult/multu
DIV_CYC, 10, MDU busy cycles loaded on div/divu
EPC_IDX, 14, CP0 register index whose in-flight write blocks eret

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_src  in  NSRC*5  source register numbers, source i at [5i+4:5i]
id_src_used  in  NSRC  source i is actually read
id_tuse  in  NSRC*TW  Tuse per source
id_dst  in  5  destination GPR, 0 = none
id_tnew  in  TW  Tnew of ID instr as seen in stage 0
id_md_start  in  2  00 none, 01 mult-class, 10 div-class
id_md_use  in  1  ID instr reads or writes HI/LO or starts MDU
id_cp0_wr  in  1  ID instr is mtc0
id_cp0_idx  in  5  mtc0 target register
id_eret  in  1  ID instr is eret
hold  in  1  global freeze (e.g. memory wait)
flush  in  1  exception/eret flush
stall  out  1  keep ID, insert bubble into stage 0
stall_cause  out  2  00 none, 01 data, 10 mdu, 11 cp0
mdu_busy  out  1  MDU counter non-zero
issue  out  1  ID instruction enters stage 0 this cycle

Behaviour:
- Stage entry: valid, dst[4:0], tnew[TW-1:0], cp0_wr, cp0_idx[4:0]. Reset: all entries invalid and zero, MDU counter 0.
- Outputs after reset: stall=0, stall_cause=00, mdu_busy=0, issue=id_valid & ~hold.
- data_hz: exists source i and valid stage k with
  - id_src_used[i], dst_k!=0, dst_k==src_i, and tuse_i < tnew_k (unsigned compare).
- mdu_hz = id_md_use & (cnt!=0).
- cp0_hz = id_eret & (some valid stage has cp0_wr & cp0_idx==EPC_IDX).
- Outputs:
  - stall = id_valid & (data_hz | mdu_hz | cp0_hz), combinational.
  - stall_cause uses priority data > mdu > cp0.
  - issue = id_valid & ~stall & ~hold.
- Clocked update, in priority order:
  - flush: all entries invalid. Overrides hold and issue. Counter unaffected.
  - else hold: scoreboard frozen, tnew not decremented.
  - else shift:
    - stage 0 <= issue ? ID fields : bubble (invalid, zero).
    - stage k <= stage k-1, with tnew decremented and saturating at 0.
    - stage DEPTH-1 is discarded.
- MDU counter (width clog2(DIV_CYC+1)) runs independently of hold and flush:
  - loads MULT_CYC or DIV_CYC on issue with id_md_start 01 or 10;
  - otherwise decrements to 0 and stays there;
  - id_md_start 11 is treated as 00.
  - A load while cnt!=0 cannot occur, because mdu_hz blocks it.
- Same-cycle flush & issue: the issuing instruction is dropped (not recorded), but an MDU load still happens.
- Reset asserted mid-operation clears all state immediately, asynchronously.
- A stage-0 entry whose tnew has reached 0 never stalls; forwarding covers it.

Optional Feature:
- HAZARD_STATS_EN defined:
  - adds outputs stat_stall_cyc (32) and stat_issue_cnt (32);
  - stat_stall_cyc increments every cycle stall=1;
  - stat_issue_cnt increments every cycle issue=1;
  - both wrap at 2^32, clear on reset, and are frozen while hold=1.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - stall_cause encodings;
  - md_start encodings;
  - scoreboard entry typedef;
  - default MULT_CYC/DIV_CYC/EPC_IDX.
- One natural sub-module, mdu_busy_cnt: load/decrement counter with mdu_busy output.

Test Plan:
- lw $t0 issued (dst 8, tnew 2), next ID addu reading $t0 with tuse 1 -> stall=1, cause 01 for exactly 1 cycle, then issue=1.
- mult issued, then mflo (md_use) in ID -> stall=1, cause 10 for 5 cycles; mdu_busy falls after 5 cycles; mflo issues in cycle 6. With div the stall lasts 10 cycles.
- mtc0 $14 issued, eret in ID next -> cause 11 stall for DEPTH cycles. mtc0 to $12 -> no stall.
- lw $t0 in stage 0, then hold=1 for 3 cycles -> stall stays 1 and tnew is not decremented. After hold drops, addu issues one cycle later.
- flush with lw $t0 in stage 0 -> next cycle dependent addu issues, stall=0. A division in flight keeps mdu_busy=1.
- reset_n pulsed low mid-division -> mdu_busy=0 and stall=0 asynchronously. With HAZARD_STATS_EN both counters read 0.
